// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   * op_e       : operation codes carried on the Op bus
//   * state_e    : FSM state encoding for muldiv_unit
//   * iter_count : number of RUN cycles needed for a given operand width
//   * op helpers : classify an op as signed / divide / iterative
// Optional feature macro: MULDIV_MADD_EN. When it is defined, MADD and MSUB
// are accepted as iterative ops. When it is not defined, they are ignored.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One shift-add or shift-subtract step is done per operand bit.
  function automatic int iter_count(input int width);
    return width;
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_iter_op(input op_e op);
`ifdef MULDIV_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};
`else
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle of the multiply/divide unit.
//   Start, Op, A, B                : request (driven by master)
//   Busy, Done, HIreg_read, LOreg_read : status and result (driven by slave)
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HIreg_read;
  logic [WIDTH-1:0] LOreg_read;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, HIreg_read, LOreg_read
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, HIreg_read, LOreg_read
  );
endinterface

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step -- one combinational iteration of unsigned multiply or
// restoring divide on a {hi, lo} working pair.
//   is_div  : 1 = divide step, 0 = multiply step
//   hi, lo  : current working pair
//             multiply: hi = partial product, lo = remaining multiplier bits
//             divide  : hi = partial remainder, lo = dividend bits / quotient
//   operand : multiplicand (multiply) or divisor (divide), unsigned
//   hi_next, lo_next : working pair after this step
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic           div_ge;

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path leaves
    // a signal unassigned and no latch can be inferred.
    hi_next = hi;
    lo_next = lo;

    // Multiply: add the multiplicand when the low multiplier bit is set,
    // then shift the (WIDTH+1)-bit sum and the multiplier right together.
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);

    // Divide: bring the next dividend bit into the remainder. The remainder
    // is always below the divisor, so the shifted value fits WIDTH+1 bits
    // and the difference, when taken, fits WIDTH bits.
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand});

    if (is_div) begin
      hi_next = div_ge ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with HI/LO result registers.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : muldiv_if.slave (Start/Op/A/B in, Busy/Done/HIreg_read/LOreg_read out)
// Iterative ops spend WIDTH cycles in RUN working on operand magnitudes, one
// FIX cycle applying signs (and accumulation), then one DONE cycle.
// MTHI/MTLO write HI/LO directly at the accept edge.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MSUB accumulation.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input logic      Clk,
  input logic      Reset,
  muldiv_if.slave  bus
);

  localparam int ITERS = iter_count(WIDTH);
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, operand_q, work_hi, work_lo, hi_q, lo_q;
  logic             a_neg_q, b_neg_q, b_zero_q, busy_q, done_q;

  // Incoming request decode (used only at the accept edge).
  op_e              op_in;
  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;

  assign op_in    = op_e'(bus.Op);
  assign in_a_neg = is_signed_op(op_in) & bus.A[WIDTH-1];
  assign in_b_neg = is_signed_op(op_in) & bus.B[WIDTH-1];
  // The negated most-negative value reads correctly as an unsigned magnitude.
  assign in_a_mag = in_a_neg ? -bus.A : bus.A;
  assign in_b_mag = in_b_neg ? -bus.B : bus.B;

  logic [WIDTH-1:0] step_hi, step_lo;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_q)),
    .hi      (work_hi),
    .lo      (work_lo),
    .operand (operand_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign correction of the magnitude results, plus optional accumulation.
  logic                 res_neg;
  logic [2*WIDTH-1:0]   prod_mag, prod_signed;
  logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

  assign res_neg = a_neg_q ^ b_neg_q;

  always_comb begin
    prod_mag       = {work_hi, work_lo};
    prod_signed    = res_neg ? -prod_mag : prod_mag;
    quo            = res_neg ? -work_lo : work_lo;
    rem            = a_neg_q ? -work_hi : work_hi;
    {fix_hi, fix_lo} = prod_signed;
    if (is_div_op(op_q)) begin
      // Most-negative / -1 needs no special case: the magnitude quotient is
      // 2^(WIDTH-1), whose negation is the most-negative value, remainder 0.
      if (b_zero_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
`ifdef MULDIV_MADD_EN
    else if (op_q == OP_MADD) begin
      {fix_hi, fix_lo} = {hi_q, lo_q} + prod_signed;
    end else if (op_q == OP_MSUB) begin
      {fix_hi, fix_lo} = {hi_q, lo_q} - prod_signed;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: only control state and the visible HI/LO are reset; the working
      // datapath registers are always loaded at accept before being read.
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.Start) begin
            if (is_iter_op(op_in)) begin
              op_q      <= op_in;
              a_q       <= bus.A;
              a_neg_q   <= in_a_neg;
              b_neg_q   <= in_b_neg;
              b_zero_q  <= (bus.B == '0);
              operand_q <= is_div_op(op_in) ? in_b_mag : in_a_mag;
              work_hi   <= '0;
              work_lo   <= is_div_op(op_in) ? in_a_mag : in_b_mag;
              cnt       <= '0;
              busy_q    <= 1'b1;
              state     <= ST_RUN;
            end else if (op_in == OP_MTHI) begin
              hi_q   <= bus.A;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else if (op_in == OP_MTLO) begin
              lo_q   <= bus.A;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= ST_FIX;
        end
        ST_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
      endcase
    end
  end

  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.HIreg_read = hi_q;
  assign bus.LOreg_read = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit (WIDTH = 32).
// Reference results come from plain 64-bit arithmetic on the operation rules.
// Expectations for MADD/MSUB follow the MULDIV_MADD_EN macro.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W        = 32;
  localparam int RUN_DONE = W + 2;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.Done === 1'b1) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: next HI/LO, whether the op responds at all, and
  // whether it is iterative (Busy for WIDTH+1 cycles).
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] hi_i, lo_i,
                        output logic [W-1:0] hi_o, lo_o,
                        output bit acts, output bit iter);
    longint sa, sb, sq, sr;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi_o = hi_i; lo_o = lo_i; acts = 1'b1; iter = 1'b1;
    case (op)
      3'b000: begin p = sa * sb; {hi_o, lo_o} = p; end
      3'b001: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; {hi_o, lo_o} = p; end
      3'b010: begin
        if (b == '0) begin hi_o = a; lo_o = '1; end
        else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin hi_o = '0; lo_o = a; end
        else begin sq = sa / sb; sr = sa % sb; lo_o = sq[W-1:0]; hi_o = sr[W-1:0]; end
      end
      3'b011: begin
        if (b == '0) begin hi_o = a; lo_o = '1; end
        else begin lo_o = a / b; hi_o = a % b; end
      end
      3'b100: begin hi_o = a; iter = 1'b0; end
      3'b101: begin lo_o = a; iter = 1'b0; end
      default: begin
`ifdef MULDIV_MADD_EN
        p = sa * sb;
        if (op == 3'b110) {hi_o, lo_o} = {hi_i, lo_i} + p;
        else              {hi_o, lo_o} = {hi_i, lo_i} - p;
`else
        acts = 1'b0; iter = 1'b0;
`endif
      end
    endcase
  endtask

  // Issue one request and follow it to Done (or to the wait bound). Returns
  // the cycle of Done counted from the accept edge (-1 if none) and a count
  // of Busy / HI-LO-stability deviations seen on the way. With wait_first=0
  // the caller is already at a falling edge (e.g. inside a DONE cycle).
  task automatic run_op(input bit wait_first, input logic [2:0] op,
                        input logic [W-1:0] a, b, input bit iter,
                        output int done_cycle, output int seq_errs);
    logic [W-1:0] hi0, lo0;
    logic exp_busy;
    if (wait_first) @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    hi0 = bus.HIreg_read; lo0 = bus.LOreg_read;
    @(negedge clk);
    bus.Start = 1'b0;
    done_cycle = -1; seq_errs = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      exp_busy = iter && (c <= W + 1);
      if (bus.Busy !== exp_busy) seq_errs++;
      if (exp_busy && (bus.HIreg_read !== hi0 || bus.LOreg_read !== lo0)) seq_errs++;
      if (bus.Done === 1'b1) begin done_cycle = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Start = 1'b1; bus.Op = 3'b101; bus.A = 32'hdead_beef; bus.B = '0;
    repeat (3) @(negedge clk);
    bus.Start = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    total++; if (bus.HIreg_read !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.HIreg_read); end
    total++; if (bus.LOreg_read !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.LOreg_read); end
    mhi = '0; mlo = '0;
  endtask

  task automatic test_mult();
    int dc, se;
    run_op(1'b1, OP_MULT, 32'hffff_ffff, 32'd5, 1'b1, dc, se);
    total++; if (bus.HIreg_read !== 32'hffff_ffff) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.HIreg_read); end
    total++; if (bus.LOreg_read !== 32'hffff_fffb) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffb", bus.LOreg_read); end
    total++; if (dc !== 34) begin bad++; $display("FAIL mult_done_cycle got=%0d exp=34", dc); end
    total++; if (se !== 0) begin bad++; $display("FAIL mult_busy_trace errors=%0d exp=0", se); end
    run_op(1'b1, OP_MULTU, 32'hffff_ffff, 32'd2, 1'b1, dc, se);
    total++; if (bus.HIreg_read !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", bus.HIreg_read); end
    total++; if (bus.LOreg_read !== 32'hffff_fffe) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.LOreg_read); end
    total++; if (dc !== RUN_DONE) begin bad++; $display("FAIL multu_done_cycle got=%0d exp=%0d", dc, RUN_DONE); end
    mhi = 32'h0000_0001; mlo = 32'hffff_fffe;
  endtask

  task automatic test_div();
    int dc, se;
    run_op(1'b1, OP_DIV, -32'sd7, 32'd2, 1'b1, dc, se);
    total++; if (bus.LOreg_read !== 32'hffff_fffd) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'hffff_ffff) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", bus.HIreg_read); end
    run_op(1'b1, OP_DIVU, 32'd100, 32'd0, 1'b1, dc, se);
    total++; if (bus.LOreg_read !== 32'hffff_ffff) begin bad++; $display("FAIL divu0_lo got=%h exp=ffffffff", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'd100) begin bad++; $display("FAIL divu0_hi got=%h exp=00000064", bus.HIreg_read); end
    total++; if (dc !== RUN_DONE || se !== 0) begin bad++; $display("FAIL divu0_timing done_cycle=%0d trace_errs=%0d exp=%0d/0", dc, se, RUN_DONE); end
    run_op(1'b1, OP_DIV, 32'h8000_0000, 32'hffff_ffff, 1'b1, dc, se);
    total++; if (bus.LOreg_read !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", bus.HIreg_read); end
    run_op(1'b1, OP_DIV, -32'sd9, 32'd0, 1'b1, dc, se);
    total++; if (bus.LOreg_read !== 32'hffff_ffff) begin bad++; $display("FAIL div0_neg_lo got=%h exp=ffffffff", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'hffff_fff7) begin bad++; $display("FAIL div0_neg_hi got=%h exp=fffffff7", bus.HIreg_read); end
    mhi = 32'hffff_fff7; mlo = 32'hffff_ffff;
  endtask

  task automatic test_madd();
    int dc, se;
    run_op(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0, dc, se);
    total++; if (dc !== 1 || se !== 0) begin bad++; $display("FAIL mthi_timing done_cycle=%0d trace_errs=%0d exp=1/0", dc, se); end
    run_op(1'b1, OP_MTLO, 32'd10, 32'd0, 1'b0, dc, se);
    total++; if (bus.LOreg_read !== 32'd10) begin bad++; $display("FAIL mtlo_lo got=%h exp=0000000a", bus.LOreg_read); end
    total++; if (dc !== 1 || se !== 0) begin bad++; $display("FAIL mtlo_timing done_cycle=%0d trace_errs=%0d exp=1/0", dc, se); end
`ifdef MULDIV_MADD_EN
    run_op(1'b1, OP_MADD, 32'd3, 32'd4, 1'b1, dc, se);
    total++; if (bus.LOreg_read !== 32'd22) begin bad++; $display("FAIL madd_lo got=%h exp=00000016", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'd0) begin bad++; $display("FAIL madd_hi got=%h exp=0", bus.HIreg_read); end
    total++; if (dc !== RUN_DONE || se !== 0) begin bad++; $display("FAIL madd_timing done_cycle=%0d trace_errs=%0d exp=%0d/0", dc, se, RUN_DONE); end
    mhi = 32'd0; mlo = 32'd22;
`else
    run_op(1'b1, OP_MADD, 32'd3, 32'd4, 1'b0, dc, se);
    total++; if (bus.LOreg_read !== 32'd10) begin bad++; $display("FAIL madd_off_lo got=%h exp=0000000a", bus.LOreg_read); end
    total++; if (bus.HIreg_read !== 32'd0) begin bad++; $display("FAIL madd_off_hi got=%h exp=0", bus.HIreg_read); end
    total++; if (dc !== -1 || se !== 0) begin bad++; $display("FAIL madd_off_response done_cycle=%0d trace_errs=%0d exp=-1/0", dc, se); end
    mhi = 32'd0; mlo = 32'd10;
`endif
  endtask

  task automatic test_reset_mid();
    int dc, se, cnt0;
    logic [W-1:0] eh, el;
    bit acts, iter;
    run_op(1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0, dc, se);
    run_op(1'b1, OP_MTLO, 32'h5678, 32'd0, 1'b0, dc, se);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'h0001_0003; bus.B = 32'h0002_0005;
    @(negedge clk);
    bus.Start = 1'b0;              // cycle 1
    repeat (14) @(negedge clk);    // cycle 15
    total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", bus.Busy); end
    reset = 1'b1;
    @(posedge clk);
    cnt0 = done_cnt;
    @(negedge clk);                // cycle 16
    reset = 1'b0;
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.Busy); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", bus.Done); end
    total++; if (bus.HIreg_read !== 32'h0 || bus.LOreg_read !== 32'h0) begin bad++; $display("FAIL abort_hilo got=%h/%h exp=0/0", bus.HIreg_read, bus.LOreg_read); end
    mhi = '0; mlo = '0;
    ref_op(OP_MULT, 32'hffff_fff0, 32'h0000_1001, mhi, mlo, eh, el, acts, iter);
    run_op(1'b1, OP_MULT, 32'hffff_fff0, 32'h0000_1001, iter, dc, se);  // Start in cycle 17
    total++; if (bus.HIreg_read !== eh || bus.LOreg_read !== el) begin bad++; $display("FAIL after_abort_result got=%h_%h exp=%h_%h", bus.HIreg_read, bus.LOreg_read, eh, el); end
    total++; if (dc !== RUN_DONE || se !== 0) begin bad++; $display("FAIL after_abort_timing done_cycle=%0d trace_errs=%0d exp=%0d/0", dc, se, RUN_DONE); end
    @(posedge clk);
    total++; if (done_cnt - cnt0 !== 1) begin bad++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt - cnt0); end
    mhi = eh; mlo = el;
  endtask

  task automatic test_busy_ignore();
    int dc, cnt0, se;
    logic [W-1:0] a, b, eh, el;
    logic exp_busy;
    bit acts, iter;
    a = $urandom; b = $urandom;
    ref_op(OP_MULTU, a, b, mhi, mlo, eh, el, acts, iter);
    @(posedge clk);
    cnt0 = done_cnt;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    dc = -1; se = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      if (c == 10) begin bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = $urandom; bus.B = 32'd3; end
      if (c == 15) bus.Start = 1'b0;
      exp_busy = (c <= W + 1);
      if (bus.Busy !== exp_busy) se++;
      if (bus.Done === 1'b1) begin dc = c; break; end
      @(negedge clk);
    end
    bus.Start = 1'b0;
    total++; if (bus.HIreg_read !== eh || bus.LOreg_read !== el) begin bad++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", bus.HIreg_read, bus.LOreg_read, eh, el); end
    total++; if (dc !== RUN_DONE || se !== 0) begin bad++; $display("FAIL ignore_timing done_cycle=%0d busy_errs=%0d exp=%0d/0", dc, se, RUN_DONE); end
    repeat (MAX_WAIT + 5) @(posedge clk);
    total++; if (done_cnt - cnt0 !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - cnt0); end
    mhi = eh; mlo = el;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    logic [W-1:0] a, b, eh, el;
    int dc, se;
    bit acts, iter;
    ops[0] = OP_MULT; ops[1] = OP_DIV; ops[2] = OP_MTLO; ops[3] = OP_MULTU;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      ref_op(ops[i], a, b, mhi, mlo, eh, el, acts, iter);
      run_op(i == 0, ops[i], a, b, iter, dc, se);
      total++; if (bus.HIreg_read !== eh || bus.LOreg_read !== el) begin bad++; $display("FAIL b2b_result[%0d] op=%0d got=%h_%h exp=%h_%h", i, ops[i], bus.HIreg_read, bus.LOreg_read, eh, el); end
      total++; if (dc !== (iter ? RUN_DONE : 1) || se !== 0) begin bad++; $display("FAIL b2b_timing[%0d] done_cycle=%0d trace_errs=%0d exp=%0d/0", i, dc, se, iter ? RUN_DONE : 1); end
      mhi = eh; mlo = el;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b, eh, el;
    int dc, se, exp_dc;
    bit acts, iter;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      ref_op(op, a, b, mhi, mlo, eh, el, acts, iter);
      exp_dc = !acts ? -1 : (iter ? RUN_DONE : 1);
      run_op(1'b1, op, a, b, iter, dc, se);
      total++; if (bus.HIreg_read !== eh || bus.LOreg_read !== el) begin bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.HIreg_read, bus.LOreg_read, eh, el); end
      total++; if (dc !== exp_dc || se !== 0) begin bad++; $display("FAIL rand_timing[%0d] op=%0d done_cycle=%0d trace_errs=%0d exp=%0d/0", i, op, dc, se, exp_dc); end
      mhi = eh; mlo = el;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
